branch_predict_ctrl: RTL and testbench

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/branch_prediction_if.sv | 25 ++
 rtl/branch_predict_ctrl_fifo.sv | 55 +++++
 rtl/branch_predict_ctrl.sv | 134 +++++++++++++
 tb/tb_branch_predict_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch-side branch prediction path: the in-flight
// prediction record, the controller state encoding and the PC reset value.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_RESET = 32'h0000_0000;
  localparam word_t PC_STEP  = 32'h0000_0004;

  typedef struct packed {
    logic [2:0] index;
    logic       predict;
    word_t      target;
    word_t      pc4;
  } bp_rec_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bp_state_e;

endpackage

// File: rtl/branch_prediction_if.sv
// Predictor <-> fetch controller bundle; bp is the predictor end, ctrl its mirror.
interface branch_prediction_if;
  import cpu_types_pkg::*;

  logic [2:0] index_I;
  logic       PC_en;
  logic       predict;
  word_t      br_target_O;
  logic [2:0] index_O;
  logic       br;
  logic [2:0] index_update;
  logic       br_taken;
  word_t      br_target_I;

  modport bp (
    input  index_I, PC_en, br, index_update, br_taken, br_target_I,
    output predict, br_target_O, index_O
  );

  modport ctrl (
    output index_I, PC_en, br, index_update, br_taken, br_target_I,
    input  predict, br_target_O, index_O
  );

endinterface

// File: rtl/branch_predict_ctrl_fifo.sv
// In-flight prediction FIFO: one record per fetched instruction, popped when
// the instruction resolves in EX. clear wins over push and pop.
module bp_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  bp_rec_t                  wdata,
  output bp_rec_t                  rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  bp_rec_t       mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (do_push_s && !rst && !clear) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch prediction controller: steers the PC from the predictor,
// tracks in-flight predictions and redirects/flushes on a mispredict in EX.
module branch_predict_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            halt,
  output word_t           pc_o,
  output logic            fetch_stall,
  output logic            flush,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_taken,
  input  word_t           ex_target,
  output logic [2:0]      index_I,
  output logic            PC_en,
  input  logic            predict,
  input  word_t           br_target_O,
  input  logic [2:0]      index_O,
  output logic            br,
  output logic [2:0]      index_update,
  output logic            br_taken,
  output word_t           br_target_I,
  output logic [CNTW-1:0] bcount,
  output logic [CNTW-1:0] mcount
);

  bp_state_e              state_r, state_n;
  bp_rec_t                head_s, push_rec_s;
  logic                   full_s, empty_s;
  logic [$clog2(DEPTH):0] fifo_count_s;
  logic                   run_s, pop_s, mispredict_s, adv_s, br_s, flush_s;
  word_t                  pc4_s, actual_s, pred_s;
  logic                   unused_s;

  assign unused_s = ^{index_O, fifo_count_s};

  assign run_s   = (state_r == ST_RUN);
  assign pc4_s   = pc_o + PC_STEP;
  assign index_I = pc_o[4:2];

  assign pop_s        = run_s & ex_valid & ~empty_s;
  assign actual_s     = (ex_branch & ex_taken) ? ex_target : head_s.pc4;
  assign pred_s       = head_s.predict ? head_s.target : head_s.pc4;
  assign mispredict_s = pop_s & (actual_s != pred_s);
  assign adv_s        = run_s & ihit & ~halt & ~mispredict_s & (~full_s | pop_s);
  assign br_s         = pop_s & ex_branch & ~RST;

  assign PC_en       = adv_s & ~RST;
  assign fetch_stall = full_s & ~pop_s;
  assign flush       = flush_s & ~RST;
  assign push_rec_s  = '{index: index_I, predict: predict, target: br_target_O, pc4: pc4_s};

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (adv_s),
    .pop   (pop_s),
    .clear (mispredict_s),
    .wdata (push_rec_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count_s)
  );

  // Predictor update port: live only in the cycle a branch resolves.
  always_comb begin
    index_update = 3'd0;
    br_taken     = 1'b0;
    br_target_I  = 32'h0000_0000;
    br           = br_s;
    if (br_s) begin
      index_update = head_s.index;
      br_taken     = ex_taken;
      br_target_I  = ex_target;
    end else begin
      br           = 1'b0;
    end
  end

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (RST) state_r <= ST_RUN;
    else     state_r <= state_n;
  end

  // Next state; FLUSH is a single squash cycle.
  always_comb begin
    state_n = state_r;
    flush_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mispredict_s) state_n = ST_FLUSH;
        else              state_n = ST_RUN;
      end
      ST_FLUSH: begin
        flush_s = 1'b1;
        state_n = ST_RUN;
      end
      default: state_n = ST_RUN;
    endcase
  end

  // Fetch PC: a redirect from EX outranks the predicted path.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_o <= PC_RESET;
    end else if (mispredict_s) begin
      pc_o <= actual_s;
    end else if (adv_s) begin
      pc_o <= predict ? br_target_O : pc4_s;
    end else begin
      pc_o <= pc_o;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bcount <= '0;
      mcount <= '0;
    end else begin
      if (br_s && (bcount != {CNTW{1'b1}}))         bcount <= bcount + CNTW'(1);
      if (mispredict_s && (mcount != {CNTW{1'b1}})) mcount <= mcount + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed vector table, hand-written corner
// sequences, then random stimulus against a queue-based reference model.
module tb_branch_predict_ctrl;

  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
  localparam int NV    = 17;
  localparam int NRAND = 3000;

  logic            CLK = 1'b0;
  logic            RST, ihit, halt, ex_valid, ex_branch, ex_taken, predict;
  logic [31:0]     ex_target, br_target_O, pc_o, br_target_I;
  logic [2:0]      index_I, index_O, index_update;
  logic            fetch_stall, flush, PC_en, br, br_taken;
  logic [CNTW-1:0] bcount, mcount;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  branch_predict_ctrl #(.DEPTH(DEPTH), .CNTW(CNTW)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .halt(halt), .pc_o(pc_o),
    .fetch_stall(fetch_stall), .flush(flush), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .index_I(index_I), .PC_en(PC_en), .predict(predict), .br_target_O(br_target_O),
    .index_O(index_O), .br(br), .index_update(index_update), .br_taken(br_taken),
    .br_target_I(br_target_I), .bcount(bcount), .mcount(mcount)
  );

  typedef struct {
    logic        ihit, halt, predict;
    logic [31:0] tgt;
    logic        exv, exb, ext;
    logic [31:0] extgt;
    logic [31:0] pc;
    logic        pen, stall, flsh, br;
    logic [2:0]  idx;
    int          bcnt, mcnt, cnt;
  } vec_t;

  typedef struct {
    bit [2:0]  idx;
    bit        pred;
    bit [31:0] tgt;
    bit [31:0] pc4;
  } mrec_t;

  vec_t  vec [NV];
  mrec_t m_q[$];
  bit [31:0] m_pc;
  bit        m_flush;
  int        m_b, m_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ih, input logic pr, input logic [31:0] tg,
                        input logic ev, input logic eb, input logic et, input logic [31:0] etg);
    @(negedge CLK);
    ihit = ih; halt = 1'b0; predict = pr; br_target_O = tg;
    ex_valid = ev; ex_branch = eb; ex_taken = et; ex_target = etg;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; ihit = 1'b1; halt = 1'b0; predict = 1'b0; br_target_O = 32'h0;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h44;
    @(negedge CLK);
    #1;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc_en", {31'd0, PC_en}, 32'd0);
    chk("rst_br", {31'd0, br}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_counts", {bcount, mcount}, 32'd0);
    chk("rst_fifo_cnt", 32'(u_dut.u_fifo.count), 32'd0);
    @(negedge CLK);
    RST = 1'b0; ihit = 1'b0; ex_valid = 1'b0;
  endtask

  // Reference model: one clock cycle from the rules, driven by current inputs.
  task automatic model_cycle();
    bit run, full, pop, misp, adv, exp_br;
    bit [31:0] actual, pred;
    mrec_t h;
    run = !m_flush;
    full = (m_q.size() == DEPTH);
    pop = run && ex_valid && (m_q.size() != 0);
    misp = 1'b0;
    h = '{3'd0, 1'b0, 32'd0, 32'd0};
    if (pop) begin
      h = m_q[0];
      actual = (ex_branch && ex_taken) ? ex_target : h.pc4;
      pred = h.pred ? h.tgt : h.pc4;
      misp = (actual != pred);
    end
    adv = run && ihit && !halt && !misp && (!full || pop);
    exp_br = pop && ex_branch && !RST;
    chk("r_pc", pc_o, m_pc);
    chk("r_index_I", 32'(index_I), 32'(m_pc[4:2]));
    chk("r_pc_en", 32'(PC_en), 32'(adv && !RST));
    chk("r_stall", 32'(fetch_stall), 32'(full && !pop));
    chk("r_flush", 32'(flush), 32'(m_flush && !RST));
    chk("r_br", 32'(br), 32'(exp_br));
    chk("r_idx_upd", 32'(index_update), exp_br ? 32'(h.idx) : 32'd0);
    chk("r_br_taken", 32'(br_taken), exp_br ? 32'(ex_taken) : 32'd0);
    chk("r_br_tgt", br_target_I, exp_br ? ex_target : 32'd0);
    chk("r_bcount", 32'(bcount), 32'(m_b));
    chk("r_mcount", 32'(mcount), 32'(m_m));
    if (RST) begin
      m_pc = 32'h0; m_q.delete(); m_flush = 1'b0; m_b = 0; m_m = 0;
    end else begin
      if (exp_br && m_b < (1 << CNTW) - 1) m_b++;
      if (misp) begin
        if (m_m < (1 << CNTW) - 1) m_m++;
        m_pc = actual;
        m_q.delete();
        m_flush = 1'b1;
      end else begin
        m_flush = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (adv) begin
          m_q.push_back('{m_pc[4:2], predict, br_target_O, m_pc + 32'd4});
          m_pc = predict ? br_target_O : m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; halt = 1'b0; predict = 1'b0; br_target_O = 32'h0;
    ex_valid = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
    index_O = 3'd0;

    //          ihit  halt  pred  tgt           exv   exb   ext   extgt         pc            pen   stall flush br    idx  b  m  cnt
    vec[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 1};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 2};
    vec[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 3};
    vec[4]  = '{1'b1, 1'b0, 1'b1, 32'h40,       1'b1, 1'b0, 1'b0, 32'h0,        32'h10,       1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 3};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h40,       1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 3};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h40,       1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 2};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h40,       32'h40,       1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 0, 0, 1};
    vec[8]  = '{1'b1, 1'b0, 1'b1, 32'h20,       1'b0, 1'b0, 1'b0, 32'h0,        32'h40,       1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1, 0, 0};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h20,       32'h20,       1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1, 0, 1};
    vec[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h80,       32'h24,       1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2, 0, 1};
    vec[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h1234,     32'h80,       1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3, 1, 0};
    vec[12] = '{1'b1, 1'b0, 1'b1, 32'h28,       1'b0, 1'b0, 1'b0, 32'h0,        32'h80,       1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3, 1, 0};
    vec[13] = '{1'b1, 1'b0, 1'b1, 32'h100,      1'b1, 1'b1, 1'b1, 32'h28,       32'h28,       1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3, 1, 1};
    vec[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h100,      1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4, 1, 1};
    vec[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h300,      32'h2C,       1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4, 2, 0};
    vec[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h2C,       1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4, 2, 0};

    do_reset();
    for (int i = 0; i < NV; i++) begin
      set_in(vec[i].ihit, vec[i].predict, vec[i].tgt, vec[i].exv, vec[i].exb, vec[i].ext, vec[i].extgt);
      chk($sformatf("v%0d_pc", i), pc_o, vec[i].pc);
      chk($sformatf("v%0d_index_I", i), 32'(index_I), 32'(vec[i].pc[4:2]));
      chk($sformatf("v%0d_pc_en", i), 32'(PC_en), 32'(vec[i].pen));
      chk($sformatf("v%0d_stall", i), 32'(fetch_stall), 32'(vec[i].stall));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vec[i].flsh));
      chk($sformatf("v%0d_br", i), 32'(br), 32'(vec[i].br));
      chk($sformatf("v%0d_idx_upd", i), 32'(index_update), 32'(vec[i].idx));
      chk($sformatf("v%0d_br_taken", i), 32'(br_taken), vec[i].br ? 32'(vec[i].ext) : 32'd0);
      chk($sformatf("v%0d_br_tgt", i), br_target_I, vec[i].br ? vec[i].extgt : 32'd0);
      chk($sformatf("v%0d_bcount", i), 32'(bcount), 32'(vec[i].bcnt));
      chk($sformatf("v%0d_mcount", i), 32'(mcount), 32'(vec[i].mcnt));
      chk($sformatf("v%0d_fifo_cnt", i), 32'(u_dut.u_fifo.count), 32'(vec[i].cnt));
    end

    // Fill to full, stall, then push and pop together while full.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("full%0d_pc", i), pc_o, (i < 4) ? 32'(4 * i) : 32'h10);
      chk($sformatf("full%0d_stall", i), 32'(fetch_stall), (i < 4) ? 32'd0 : 32'd1);
      chk($sformatf("full%0d_pc_en", i), 32'(PC_en), (i < 4) ? 32'd1 : 32'd0);
    end
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_pop_stall", 32'(fetch_stall), 32'd0);
    chk("full_pop_pc_en", 32'(PC_en), 32'd1);
    chk("full_pop_cnt", 32'(u_dut.u_fifo.count), 32'd4);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("full_after_cnt", 32'(u_dut.u_fifo.count), 32'd4);
    chk("full_after_pc", pc_o, 32'h14);

    // Redirect to the top of the address space, then wrap.
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_misp_br", 32'(br), 32'd1);
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_flush", 32'(flush), 32'd1);
    chk("wrap_top_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_flush_pc_en", 32'(PC_en), 32'd0);
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_index_I", 32'(index_I), 32'd7);
    chk("wrap_pc_en", 32'(PC_en), 32'd1);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc_o, 32'h0);

    // Reset landing on the flush cycle.
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rstfl_flush_before", 32'(flush), 32'd1);
    chk("rstfl_mcount_before", 32'(mcount), 32'd1);
    RST = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    RST = 1'b0;
    #1;
    chk("rstfl_pc", pc_o, 32'h0);
    chk("rstfl_flush", 32'(flush), 32'd0);
    chk("rstfl_counts", 32'({bcount, mcount}), 32'd0);

    // Random traffic against the reference model.
    do_reset();
    m_pc = 32'h0; m_q.delete(); m_flush = 1'b0; m_b = 0; m_m = 0;
    for (int i = 0; i < NRAND; i++) begin
      @(negedge CLK);
      RST         = ($urandom_range(399) == 0);
      ihit        = ($urandom_range(3) != 0);
      halt        = ($urandom_range(9) == 0);
      predict     = ($urandom_range(2) == 0);
      br_target_O = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
      ex_valid    = ($urandom_range(1) == 1);
      if (m_q.size() != 0 && $urandom_range(1) == 1) begin
        ex_branch = 1'b1;
        ex_taken  = m_q[0].pred;
        ex_target = m_q[0].pred ? m_q[0].tgt : ($urandom & 32'h0000_0FFC);
      end else begin
        ex_branch = ($urandom_range(1) == 1);
        ex_taken  = ($urandom_range(1) == 1);
        ex_target = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
      end
      #1;
      model_cycle();
    end

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
